// File: rtl/sram_ctrl_pkg.sv
// Shared SRAM controller definitions: bus widths and the arbiter FSM state encoding.
package sram_ctrl_pkg;
  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned SRAM_BE_W   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// Host-side request/ack bundle for the two ports sharing the SRAM arbiter.
interface sram_arbiter_if;
  import sram_ctrl_pkg::*;

  logic                   req0;
  logic                   we0;
  logic [SRAM_ADDR_W-1:0] addr0;
  logic [SRAM_DATA_W-1:0] wdata0;
  logic [SRAM_BE_W-1:0]   be0;
  logic                   ack0;

  logic                   req1;
  logic                   we1;
  logic [SRAM_ADDR_W-1:0] addr1;
  logic [SRAM_DATA_W-1:0] wdata1;
  logic [SRAM_BE_W-1:0]   be1;
  logic                   ack1;

  logic [SRAM_DATA_W-1:0] rdata;
  logic                   busy;

  modport slave (
    input  req0, we0, addr0, wdata0, be0,
    input  req1, we1, addr1, wdata1, be1,
    output ack0, ack1, rdata, busy
  );

  modport master (
    output req0, we0, addr0, wdata0, be0,
    output req1, we1, addr1, wdata1, be1,
    input  ack0, ack1, rdata, busy
  );
endinterface

// File: rtl/sram_rr_arb.sv
// Two-port round-robin grant: a sole requester wins, on contention the port not served last wins.
module sram_rr_arb (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o,
  output logic       valid_o
);
  always_comb begin
    valid_o = |req_i;
    if (&req_i) grant_o = ~last_i;
    else        grant_o = req_i[1];
  end
endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter driving an asynchronous SRAM with a SETUP / ACCESS x N / DONE strobe sequence.
module sram_arbiter
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  sram_arbiter_if.slave          host,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  inout  wire  [SRAM_DATA_W-1:0] sram_data,
  output logic                   write_enable,
  output logic                   output_enable,
  output logic                   chip_enable,
  output logic                   lower_byte_ctrl,
  output logic                   upper_byte_control
);
  localparam int unsigned    CNT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   port_q, we_q, last_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [SRAM_DATA_W-1:0] wdata_q, rdata_q;
  logic [SRAM_BE_W-1:0]   be_q;

  logic grant, grant_valid, load, sample_rd;
  logic lane_act, drive_bus;

  sram_rr_arb u_arb (
    .req_i   ({host.req1, host.req0}),
    .last_i  (last_q),
    .grant_o (grant),
    .valid_o (grant_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    sample_rd = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          load    = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          sample_rd = ~we_q & (|be_q);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // last_q resets to port 1 so that port 0 wins the first contention.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (load) begin
        port_q  <= grant;
        last_q  <= grant;
        we_q    <= grant ? host.we1    : host.we0;
        addr_q  <= grant ? host.addr1  : host.addr0;
        wdata_q <= grant ? host.wdata1 : host.wdata0;
        be_q    <= grant ? host.be1    : host.be0;
      end
      if (sample_rd) rdata_q <= sram_data;
    end
  end

  // A zero byte-enable request walks the FSM but never asserts any strobe.
  always_comb begin
    lane_act           = ((state_q == SETUP) || (state_q == ACCESS)) && (|be_q);
    chip_enable        = ~lane_act;
    lower_byte_ctrl    = ~(lane_act & be_q[0]);
    upper_byte_control = ~(lane_act & be_q[1]);
    write_enable       = ~((state_q == ACCESS) &  we_q & (|be_q));
    output_enable      = ~((state_q == ACCESS) & ~we_q & (|be_q));
    drive_bus          = we_q & (state_q != IDLE);
  end

  assign sram_data  = drive_bus ? wdata_q : 'z;
  assign sram_addr  = addr_q;
  assign host.ack0  = (state_q == DONE) & ~port_q;
  assign host.ack1  = (state_q == DONE) &  port_q;
  assign host.busy  = (state_q != IDLE);
  assign host.rdata = rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small behavioural SRAM on the shared bus.
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] sram_addr;
    wire  [15:0] sram_data;
    logic        write_enable, output_enable, chip_enable, lower_byte_ctrl, upper_byte_control;

    sram_arbiter_if hif ();

    sram_arbiter #(.ACCESS_CYCLES(2)) dut (
        .clock              (clk),
        .reset              (rst_n),
        .host               (hif),
        .sram_addr          (sram_addr),
        .sram_data          (sram_data),
        .write_enable       (write_enable),
        .output_enable      (output_enable),
        .chip_enable        (chip_enable),
        .lower_byte_ctrl    (lower_byte_ctrl),
        .upper_byte_control (upper_byte_control)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:15];
    always @(posedge clk) begin
        if (!chip_enable && !write_enable) begin
            if (!lower_byte_ctrl)    mem[sram_addr[3:0]][7:0]  <= sram_data[7:0];
            if (!upper_byte_control) mem[sram_addr[3:0]][15:8] <= sram_data[15:8];
        end
    end
    assign sram_data = (!chip_enable && !output_enable && write_enable) ? mem[sram_addr[3:0]] : 'z;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {chip_enable, write_enable, output_enable, lower_byte_ctrl, upper_byte_control};
    endfunction

    int          r_cycles, r_we_lo, r_oe_lo, r_ce_lo, r_lb_lo, r_ub_lo, r_other_ack;
    logic [15:0] r_data_done, r_rdata;
    logic [17:0] r_addr_ack;

    task automatic do_access(input logic port, input logic we, input logic [17:0] addr,
                             input logic [15:0] wdata, input logic [1:0] be, input logic drop);
        logic got;
        got = 1'b0;
        r_cycles = 0; r_we_lo = 0; r_oe_lo = 0; r_ce_lo = 0; r_lb_lo = 0; r_ub_lo = 0; r_other_ack = 0;
        @(negedge clk);
        if (!port) begin
            hif.req0 = 1'b1; hif.we0 = we; hif.addr0 = addr; hif.wdata0 = wdata; hif.be0 = be;
        end else begin
            hif.req1 = 1'b1; hif.we1 = we; hif.addr1 = addr; hif.wdata1 = wdata; hif.be1 = be;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            r_cycles++;
            if (drop && r_cycles == 1) begin
                if (!port) begin hif.req0 = 1'b0; hif.addr0 = 18'h5; hif.wdata0 = 16'h0BAD; end
                else       begin hif.req1 = 1'b0; hif.addr1 = 18'h5; hif.wdata1 = 16'h0BAD; end
            end
            if (!write_enable)       r_we_lo++;
            if (!output_enable)      r_oe_lo++;
            if (!chip_enable)        r_ce_lo++;
            if (!lower_byte_ctrl)    r_lb_lo++;
            if (!upper_byte_control) r_ub_lo++;
            if (port ? hif.ack0 : hif.ack1) r_other_ack++;
            if (port ? hif.ack1 : hif.ack0) begin
                r_data_done = sram_data;
                r_addr_ack  = sram_addr;
                r_rdata     = hif.rdata;
                got = 1'b1;
                break;
            end
        end
        check_eq("ack_seen", {31'd0, got}, 32'd1);
        if (!port) hif.req0 = 1'b0;
        else       hif.req1 = 1'b0;
    endtask

    initial begin
        int          order [4];
        int          ack_cyc [4];
        int          n_acks, overlap, cyc, stray;
        hif.req0 = 1'b0; hif.we0 = 1'b0; hif.addr0 = '0; hif.wdata0 = '0; hif.be0 = '0;
        hif.req1 = 1'b0; hif.we1 = 1'b0; hif.addr1 = '0; hif.wdata1 = '0; hif.be1 = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_ack0",    {31'd0, hif.ack0}, 32'd0);
        check_eq("rst_ack1",    {31'd0, hif.ack1}, 32'd0);
        check_eq("rst_busy",    {31'd0, hif.busy}, 32'd0);
        check_eq("rst_rdata",   {16'd0, hif.rdata}, 32'h0);
        check_eq("rst_addr",    {14'd0, sram_addr}, 32'h0);
        check_eq("rst_strobes", {27'd0, strobes()}, 32'h1F);
        rst_n = 1'b1;

        do_access(1'b0, 1'b1, 18'h00001, 16'hA5A5, 2'b11, 1'b0);
        check_eq("wr_latency",   r_cycles,    4);
        check_eq("wr_we_low",    r_we_lo,     2);
        check_eq("wr_oe_low",    r_oe_lo,     0);
        check_eq("wr_lb_low",    r_lb_lo,     3);
        check_eq("wr_data_done", {16'd0, r_data_done}, 32'hA5A5);
        check_eq("wr_addr",      {14'd0, r_addr_ack},  32'h1);
        check_eq("wr_other_ack", r_other_ack, 0);

        do_access(1'b1, 1'b0, 18'h00001, 16'h0000, 2'b11, 1'b0);
        check_eq("rd_latency", r_cycles, 4);
        check_eq("rd_oe_low",  r_oe_lo,  2);
        check_eq("rd_we_low",  r_we_lo,  0);
        check_eq("rd_rdata",   {16'd0, r_rdata}, 32'hA5A5);
        @(negedge clk);
        check_eq("idle_addr_hold", {14'd0, sram_addr}, 32'h1);
        check_eq("idle_strobes",   {27'd0, strobes()}, 32'h1F);
        check_eq("idle_rdata",     {16'd0, hif.rdata}, 32'hA5A5);

        do_access(1'b0, 1'b1, 18'h00001, 16'h1234, 2'b01, 1'b0);
        check_eq("bl_lb_low",  r_lb_lo, 3);
        check_eq("bl_ub_low",  r_ub_lo, 0);
        check_eq("bl_we_low",  r_we_lo, 2);

        do_access(1'b1, 1'b0, 18'h00001, 16'h0000, 2'b11, 1'b1);
        check_eq("drop_latency", r_cycles, 4);
        check_eq("drop_addr",    {14'd0, r_addr_ack}, 32'h1);
        check_eq("bl_readback",  {16'd0, r_rdata},    32'hA534);

        do_access(1'b0, 1'b1, 18'h00002, 16'hFFFF, 2'b00, 1'b0);
        check_eq("be0_latency", r_cycles, 4);
        check_eq("be0_activity", r_we_lo + r_oe_lo + r_ce_lo + r_lb_lo + r_ub_lo, 0);

        // Contention straight after a reset: port 0 first, then strict alternation.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        hif.req0 = 1'b1; hif.we0 = 1'b0; hif.addr0 = 18'h1; hif.be0 = 2'b11;
        hif.req1 = 1'b1; hif.we1 = 1'b0; hif.addr1 = 18'h1; hif.be1 = 2'b11;
        n_acks = 0; overlap = 0;
        for (int i = 0; i < 60 && n_acks < 4; i++) begin
            @(negedge clk);
            if (hif.ack0 && hif.ack1) overlap++;
            if (hif.ack0) begin order[n_acks] = 0; ack_cyc[n_acks] = i; n_acks++; end
            else if (hif.ack1) begin order[n_acks] = 1; ack_cyc[n_acks] = i; n_acks++; end
        end
        hif.req0 = 1'b0; hif.req1 = 1'b0;
        check_eq("cont_count",   n_acks,  4);
        check_eq("cont_overlap", overlap, 0);
        for (int i = 0; i < 4; i++) check_eq($sformatf("cont_order%0d", i), order[i], i % 2);
        check_eq("cont_spacing", ack_cyc[1] - ack_cyc[0], 5);
        check_eq("cont_rdata",   {16'd0, hif.rdata}, 32'hA534);

        @(negedge clk);
        @(negedge clk);
        hif.req0 = 1'b1; hif.we0 = 1'b1; hif.addr0 = 18'h3; hif.wdata0 = 16'h5555; hif.be0 = 2'b11;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_eq("mid_in_access", {31'd0, write_enable}, 32'd0);
        rst_n = 1'b0;
        hif.req0 = 1'b0;
        #1;
        check_eq("mid_strobes", {27'd0, strobes()}, 32'h1F);
        check_eq("mid_busy",    {31'd0, hif.busy},  32'd0);
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (hif.ack0 || hif.ack1) stray++;
        end
        check_eq("mid_no_ack", stray, 0);
        rst_n = 1'b1;

        do_access(1'b1, 1'b0, 18'h00001, 16'h0000, 2'b11, 1'b0);
        check_eq("post_rst_latency", r_cycles, 4);
        check_eq("post_rst_rdata",   {16'd0, r_rdata}, 32'hA534);

        cyc = 0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
